// File: rtl/bus_pkg.sv
// Shared definitions for the bus requester and its command queue.
package bus_pkg;

    localparam int BUS_ADDR_WIDTH  = 8;
    localparam int BUS_DATA_WIDTH  = 8;
    localparam int NUM_BUS_DEVICES = 4;

    // Requester FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2
    } req_state_t;

    // One queued transfer command.
    typedef struct packed {
        logic                      write;
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [BUS_DATA_WIDTH-1:0] data;
    } bus_cmd_t;

    localparam bus_cmd_t BUS_CMD_ZERO = {1'b0, {BUS_ADDR_WIDTH{1'b0}}, {BUS_DATA_WIDTH{1'b0}}};

endpackage

// File: rtl/bus_cmd_fifo.sv
// Synchronous command queue. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
// A push while full is taken only when the head leaves in the same cycle.
module bus_cmd_fifo import bus_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  bus_cmd_t                 i_cmd,
    input  logic                     i_pop,
    output bus_cmd_t                 o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    bus_cmd_t         r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage and pointer update; the head is read before the edge, so a
    // write into the slot being popped while full is safe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {(PTR_W+1){1'b0}};
            r_rd_ptr <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= BUS_CMD_ZERO;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= i_cmd;
                r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

endmodule

// File: rtl/bus_requester.sv
// Device-side client of the round-robin bus arbiter: queues commands,
// requests the bus while work is pending, drives one word per grant and
// returns read data as a one-cycle response.
module bus_requester import bus_pkg::*; #(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  request,
    input  logic                  grant,
    output logic                  bus_valid,
    output logic                  bus_write,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  spurious_grant
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    req_state_t            r_state;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_spurious_grant;

    bus_cmd_t              w_push_cmd;
    bus_cmd_t              w_head;
    logic                  w_empty;
    logic                  w_full;
    logic [CNT_W-1:0]      w_count;
    logic                  w_beat;
    logic                  w_push;
    logic                  w_nonempty_next;

    assign w_push_cmd.write = cmd_write;
    assign w_push_cmd.addr  = BUS_ADDR_WIDTH'(cmd_addr);
    assign w_push_cmd.data  = BUS_DATA_WIDTH'(cmd_data);

    // A beat only happens when we are actually requesting; any other grant is spurious.
    assign w_beat    = grant && (r_state == REQ);
    // A full queue still takes a command in the cycle its head goes out on the bus.
    assign cmd_ready = !w_full || w_beat;
    assign w_push    = cmd_valid && cmd_ready;
    // Queue occupancy after this edge is non-zero.
    assign w_nonempty_next = w_push ||
                             (!w_empty && !(w_beat && (w_count == {{(CNT_W-1){1'b0}}, 1'b1})));

    bus_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_cmd   (w_push_cmd),
        .i_pop   (w_beat),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign request        = (r_state == REQ);
    assign bus_valid      = w_beat;
    assign bus_write      = w_beat ? w_head.write : 1'b0;
    assign bus_addr       = w_beat ? ADDR_WIDTH'(w_head.addr) : {ADDR_WIDTH{1'b0}};
    assign bus_wdata      = w_beat ? DATA_WIDTH'(w_head.data) : {DATA_WIDTH{1'b0}};
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign spurious_grant = r_spurious_grant;

    // Request FSM with read-response capture and the sticky spurious-grant flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_rsp_valid      <= 1'b0;
            r_rsp_data       <= {DATA_WIDTH{1'b0}};
            r_spurious_grant <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (grant && (r_state != REQ)) begin
                r_spurious_grant <= 1'b1;
            end else begin
                r_spurious_grant <= r_spurious_grant;
            end
            case (r_state)
                IDLE: begin
                    if (w_nonempty_next) begin
                        r_state <= REQ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (w_beat && !w_head.write) begin
                        r_state <= RD_WAIT;
                    end else if (w_nonempty_next) begin
                        r_state <= REQ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= bus_rdata;
                    if (w_nonempty_next) begin
                        r_state <= REQ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
